uart_tx_streamer: RTL
=====================

Name: uart_tx_streamer

Overview:
- Read side of the UART receive buffer.
- Bytes captured from uart_rx are written into an internal 1 KB ring buffer.
- An FSM drains the buffer one byte at a time into uart_tx over its DV/Done handshake.
- Sits in the codec top between uart_rx (write side) and uart_tx (read side); later replaced by a compressor output stage with the same read-side handshake.

Parameters:
- ADDR_W, 10: buffer address width; depth = 2**ADDR_W bytes (1024).
- DATA_W, 8: byte width.
- TERM_BYTE, 8'h0A: terminator value; used only with TX_TERMINATOR_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  one clock; reset is asynchronous and active-low
- wr_valid  in  1  one-cycle strobe, wr_data valid (driven by uart_rx o_Rx_DV)
- wr_data  in  DATA_W  byte to store
- drain_en  in  1  level; while high, buffered bytes are transmitted
- clear_ovf  in  1  one-cycle pulse, clears overflow
- tx_active  in  1  uart_tx o_Tx_Active
- tx_done  in  1  uart_tx o_Tx_Done, one-cycle pulse
- tx_dv  out  1  one-cycle start strobe to uart_tx i_Tx_DV
- tx_byte  out  DATA_W  byte to uart_tx i_Tx_Byte, held stable from tx_dv until tx_done
- count  out  ADDR_W+1  bytes currently buffered, 0..2**ADDR_W
- empty  out  1  count == 0
- full  out  1  count == 2**ADDR_W
- overflow  out  1  sticky; a write was dropped

Behaviour:
Reset values:
- wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0.
- tx_dv = 0, tx_byte = 0, FSM in IDLE.
- Buffer contents are not cleared.

Pointers:
- wr_ptr and rd_ptr are ADDR_W+1 bits and wrap naturally modulo 2**(ADDR_W+1).
- count = wr_ptr - rd_ptr. full/empty are derived combinationally from count.

Write side:
- On wr_valid && !full: mem[wr_ptr[ADDR_W-1:0]] <= wr_data, wr_ptr++.
- On wr_valid && full: byte dropped, overflow <= 1.
- overflow clears only on clear_ovf. If a drop and clear_ovf occur in the same cycle, the set wins.

Memory:
- Single write port, single synchronous read port (BRAM inference); read data is available one cycle after the address.

FSM states and transitions:
- IDLE: if drain_en && !empty && !tx_active, go to FETCH. Read address = rd_ptr.
- FETCH: tx_byte <= mem read data; go to STROBE.
- STROBE: tx_dv = 1 for exactly this cycle; rd_ptr++; go to WAIT.
- WAIT: on tx_done, go to IDLE. The IDLE re-check gives a 3-cycle done-to-next-dv gap.

Latency and read-side edge cases:
- drain_en rising with data present: tx_dv asserts in the 3rd cycle (IDLE, FETCH, STROBE).
- tx_done arrives before WAIT: not possible, since uart_tx needs ≥1 bit time.
- tx_done outside WAIT is ignored.
- drain_en deasserted mid-byte: current byte completes; FSM then holds in IDLE.

Simultaneous events and boundaries:
- Simultaneous write and read increment: both applied; count unchanged.
- full is evaluated on pre-edge state, so a write while full is dropped even if STROBE frees a slot in the same cycle.
- Emptying to 0 during WAIT: FSM returns to IDLE and waits.

Reset mid-operation:
- Pointers and FSM return to reset values immediately.
- A byte already started in uart_tx finishes on the line unaffected. Its tx_done is ignored because the FSM is in IDLE.

Optional Feature:
Macro TX_TERMINATOR_EN.
- Defined: adds state TERM. When tx_done arrives in WAIT and the buffer is now empty, the FSM sends TERM_BYTE once (FETCH skipped: tx_byte <= TERM_BYTE, then STROBE without rd_ptr++, then WAIT), then returns to IDLE. A terminator is emitted once per empty transition, and not if the buffer never held data.
- Undefined: no TERM state, no terminator; TERM_BYTE unused.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, FETCH, STROBE, WAIT, TERM.
  - Default ADDR_W/DATA_W.
  - Default UART clocks-per-bit constant (100).
- One natural sub-module, sdp_byte_ram: simple dual-port RAM, sync write, sync read.
- Pointer/count logic and FSM stay in uart_tx_streamer.

Test Plan:
1. Reset low during write of 0x55, release: count = 0, empty = 1, tx_dv = 0, overflow = 0.
2. Write 0x41, 0x42, 0x43 with drain_en = 0 → count = 3. Raise drain_en with a uart_tx model (100 clocks/bit) → tx_byte sequence 0x41, 0x42, 0x43, each with a one-cycle tx_dv; first tx_dv 3 cycles after drain_en; count = 0 at end.
3. Write 1025 bytes (i mod 256), no drain → full = 1, count = 1024, overflow = 1. clear_ovf → overflow = 0. Drain → 0x00..0xFF ×4 in order, byte 1025 absent.
4. Wrap: write and drain 1000 bytes, then 100 more → pointers cross 1023→0 and 100 bytes arrive in order.
5. Drop drain_en mid-byte → exactly one tx_done follows, no further tx_dv until drain_en returns.
6. TX_TERMINATOR_EN defined: write 0x31, drain → line carries 0x31 then 0x0A. With the macro undefined, only 0x31.

Source files
------------

// File: rtl/uart_tx_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_streamer_pkg
// Description : Shared definitions for the UART transmit streamer: FSM state
//               encoding, default buffer geometry and the default UART bit
//               period used by the surrounding codec.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_streamer_pkg;

  localparam int C_DEF_ADDR_W       = 10;   // 1 KB ring buffer
  localparam int C_DEF_DATA_W       = 8;    // byte-wide
  localparam int C_DEF_CLKS_PER_BIT = 100;  // uart_tx bit period in clocks

  // Read-side FSM encoding. ST_TERM is only reachable when the terminator
  // feature is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_TERM   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_streamer_ram.sv
`default_nettype none
// ============================================================================
// Module      : sdp_byte_ram
// Description : Simple dual-port RAM, one synchronous write port and one
//               synchronous read port (read data one cycle after address).
//               Written to infer block RAM; contents are never reset.
// Ports       : i_clk   - clock
//               i_we    - write enable
//               i_waddr - write address
//               i_wdata - write data
//               i_raddr - read address
//               o_rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_byte_ram
  import uart_tx_streamer_pkg::*;
#(
  parameter int ADDR_W = C_DEF_ADDR_W,
  parameter int DATA_W = C_DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_streamer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_streamer
// Description : Ring buffer between uart_rx (write side) and uart_tx (read
//               side). Received bytes are stored in a 2**ADDR_W byte buffer
//               and drained one at a time through the uart_tx DV/Done
//               handshake while i_drain_en is high.
// Macro       : TX_TERMINATOR_EN - when defined, a single TERM_BYTE is sent
//               each time the buffer drains to empty.
// Ports       : i_clk       - system clock
//               i_rst_n     - asynchronous active-low reset
//               i_wr_valid  - one-cycle strobe, i_wr_data valid
//               i_wr_data   - byte to store
//               i_drain_en  - level, enables transmission of buffered bytes
//               i_clear_ovf - one-cycle pulse, clears o_overflow
//               i_tx_active - uart_tx busy
//               i_tx_done   - uart_tx frame complete, one-cycle pulse
//               o_tx_dv     - one-cycle start strobe to uart_tx
//               o_tx_byte   - byte to uart_tx, stable from o_tx_dv to done
//               o_count     - bytes buffered, 0..2**ADDR_W
//               o_empty     - o_count == 0
//               o_full      - o_count == 2**ADDR_W
//               o_overflow  - sticky, a write was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_streamer
  import uart_tx_streamer_pkg::*;
#(
  parameter int ADDR_W = C_DEF_ADDR_W,
  parameter int DATA_W = C_DEF_DATA_W
`ifdef TX_TERMINATOR_EN
  ,
  parameter logic [DATA_W-1:0] TERM_BYTE = DATA_W'('h0A)
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_drain_en,
  input  logic              i_clear_ovf,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              o_tx_dv,
  output logic [DATA_W-1:0] o_tx_byte,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
);

  localparam logic [ADDR_W:0] C_PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] C_DEPTH   = (ADDR_W+1)'(2**ADDR_W);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_overflow;
  logic [DATA_W-1:0] r_tx_byte;
  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W:0]   w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_en;
  logic              w_rd_inc;
  logic [DATA_W-1:0] w_rd_data;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == C_DEPTH);
  assign w_wr_en = i_wr_valid && !w_full;

`ifdef TX_TERMINATOR_EN
  // High while the frame in flight is the terminator, so the WAIT that
  // follows it does not emit a second terminator and STROBE leaves rd_ptr.
  logic r_in_term;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_term <= 1'b0;
    end else if (r_state == ST_TERM) begin
      r_in_term <= 1'b1;
    end else if ((r_state == ST_WAIT) && i_tx_done) begin
      r_in_term <= 1'b0;
    end
  end

  assign w_rd_inc = (r_state == ST_STROBE) && !r_in_term;
`else
  assign w_rd_inc = (r_state == ST_STROBE);
`endif

  sdp_byte_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (i_wr_data),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_tx_byte  <= '0;
      r_state    <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_rd_inc) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (i_wr_valid && w_full) begin
        r_overflow <= 1'b1;
      end else if (i_clear_ovf) begin
        r_overflow <= 1'b0;
      end
      if (r_state == ST_FETCH) begin
        r_tx_byte <= w_rd_data;
      end
`ifdef TX_TERMINATOR_EN
      if (r_state == ST_TERM) begin
        r_tx_byte <= TERM_BYTE;
      end
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_drain_en && !w_empty && !i_tx_active) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH:  w_state_nxt = ST_STROBE;
      ST_STROBE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
`ifdef TX_TERMINATOR_EN
          if (w_empty && !r_in_term) begin
            w_state_nxt = ST_TERM;
          end else begin
            w_state_nxt = ST_IDLE;
          end
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef TX_TERMINATOR_EN
      ST_TERM:   w_state_nxt = ST_STROBE;
`endif
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_tx_dv    = (r_state == ST_STROBE);
  assign o_tx_byte  = r_tx_byte;
  assign o_count    = w_count;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire
